// File: rtl/bram_port_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_master_if
//  Purpose  : Bundles the request/response handshake of the CPU side together
//             with one byte-wide BRAM port.
//  Modports : master - the bram_port_master block (accepts requests, drives
//                      responses and the BRAM address/data/write-enable)
//             slave  - the surrounding CPU / BRAM side
//  Signals  : req_valid, req_ready, req_wr, req_addr, req_wdata
//             rsp_valid, rsp_wr, rsp_rdata
//             m_wr, m_addr, m_din, m_dout
//  Revision : 1.0 - initial release
// ============================================================================
interface bram_port_master_if #(
    parameter int DATA  = 8,
    parameter int ADDR  = 16,
    parameter int BYTES = 2
);
    // CPU-side request
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wr;
    logic [ADDR-1:0]         req_addr;
    logic [BYTES*DATA-1:0]   req_wdata;
    // CPU-side response
    logic                    rsp_valid;
    logic                    rsp_wr;
    logic [BYTES*DATA-1:0]   rsp_rdata;
    // BRAM port
    logic                    m_wr;
    logic [ADDR-1:0]         m_addr;
    logic [DATA-1:0]         m_din;
    logic [DATA-1:0]         m_dout;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, m_dout,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata, m_wr, m_addr, m_din
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, m_dout,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata, m_wr, m_addr, m_din
    );
endinterface
`default_nettype wire

// File: rtl/bram_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_master
//  Purpose  : CPU-side initiator for one port of a byte-wide data BRAM.
//             Splits each word load/store into BYTES sequential byte accesses,
//             honouring the BRAM's one-cycle registered read latency, and
//             returns a one-cycle response pulse.
//  Ports    : clk  - clock shared with the BRAM port
//             rst  - asynchronous active-high reset
//             bus  - bram_port_master_if.master (request, response, BRAM port)
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_master #(
    parameter int DATA  = 8,
    parameter int ADDR  = 16,
    parameter int BYTES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    bram_port_master_if.master        bus
);

    localparam int c_WORD = BYTES * DATA;
    localparam int c_KW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(BYTES - 1);
    localparam logic [c_KW-1:0] c_K_ONE  = c_KW'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [c_KW-1:0]   r_k;
    logic              r_wr;
    logic [ADDR-1:0]   r_base;
    logic [c_WORD-1:0] r_wdata;
    logic [c_WORD-1:0] r_rdata;

    logic              w_accept;
    logic              w_last;
    logic [ADDR-1:0]   w_addr;

    assign w_accept = bus.req_valid && (r_state == c_IDLE);
    assign w_last   = (r_k == c_K_LAST);
    // Natural ADDR-bit overflow gives the required wrap from all-ones to 0.
    assign w_addr   = r_base + ADDR'(r_k);

    assign bus.rsp_rdata = r_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_wr    = 1'b0;
        bus.m_wr      = 1'b0;
        bus.m_addr    = '0;
        bus.m_din     = '0;
        case (r_state)
            c_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                bus.m_addr = w_addr;
                if (r_wr) begin
                    bus.m_wr  = 1'b1;
                    bus.m_din = r_wdata[r_k*DATA +: DATA];
                    if (w_last) begin
                        w_next = c_RESP;
                    end
                end else begin
                    w_next = c_CAPTURE;
                end
            end
            c_CAPTURE: begin
                // Address held so the BRAM output stays on the same byte.
                bus.m_addr = w_addr;
                w_next     = w_last ? c_RESP : c_ISSUE;
            end
            c_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_wr    = r_wr;
                w_next        = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, byte counter and load data assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_wr    <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_k     <= '0;
                        r_wr    <= bus.req_wr;
                        r_base  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                    end
                end
                c_ISSUE: begin
                    // Loads advance k in CAPTURE, once the byte has landed.
                    if (r_wr && !w_last) begin
                        r_k <= r_k + c_K_ONE;
                    end
                end
                c_CAPTURE: begin
                    r_rdata[r_k*DATA +: DATA] <= bus.m_dout;
                    if (!w_last) begin
                        r_k <= r_k + c_K_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_port_master
//  Purpose  : Self-checking bench for bram_port_master. A behavioural BRAM
//             sits on the port; a separate reference memory predicts load
//             results, byte sequences and response latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_master;

    localparam int DATA  = 8;
    localparam int ADDR  = 16;
    localparam int BYTES = 2;
    localparam int WORD  = BYTES * DATA;
    localparam int DEPTH = 1 << ADDR;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bram_port_master_if #(.DATA(DATA), .ADDR(ADDR), .BYTES(BYTES)) bus ();

    bram_port_master #(.DATA(DATA), .ADDR(ADDR), .BYTES(BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural BRAM: synchronous write, registered read-first output.
    logic [DATA-1:0] bram    [0:DEPTH-1];
    // Expected memory contents as seen by the CPU.
    logic [DATA-1:0] ref_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (bus.m_wr) begin
            bram[bus.m_addr] <= bus.m_din;
        end
        bus.m_dout <= bram[bus.m_addr];
    end

    int              n_checks;
    int              n_fail;
    logic [WORD-1:0] last_rdata;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Issue one request and follow it cycle by cycle to its response.
    // hold=1 leaves req_valid asserted after acceptance (back-to-back traffic);
    // otherwise the request fields are scrambled while the block is busy.
    task automatic do_req(input bit wr, input logic [ADDR-1:0] addr,
                          input logic [WORD-1:0] wd, input bit hold);
        int              wait_c;
        int              lat;
        logic [WORD-1:0] exp_rd;
        logic [ADDR-1:0] a;
        for (int b = 0; b < BYTES; b++) begin
            a = addr + ADDR'(b);
            exp_rd[b*DATA +: DATA] = ref_mem[a];
        end
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        wait_c = 0;
        while (!bus.req_ready && wait_c < 20) begin
            @(posedge clk);
            #1;
            wait_c++;
        end
        check_value("accept_timeout", 64'(wait_c < 20), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req_valid = 1'b0;
            bus.req_wr    = 1'($urandom);
            bus.req_addr  = ADDR'($urandom);
            bus.req_wdata = WORD'($urandom);
        end
        lat = wr ? BYTES + 1 : 2 * BYTES + 1;
        for (int n = 1; n < lat; n++) begin
            check_value("busy_ready", 64'(bus.req_ready), 64'd0);
            check_value("early_rsp", 64'(bus.rsp_valid), 64'd0);
            check_value("m_wr", 64'(bus.m_wr), 64'(wr));
            if (wr) begin
                a = addr + ADDR'(n - 1);
                check_value("st_addr", 64'(bus.m_addr), 64'(a));
                check_value("st_din", 64'(bus.m_din), 64'(wd[(n-1)*DATA +: DATA]));
            end else begin
                a = addr + ADDR'((n - 1) / 2);
                check_value("ld_addr", 64'(bus.m_addr), 64'(a));
            end
            @(posedge clk);
            #1;
        end
        check_value("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_value("rsp_wr", 64'(bus.rsp_wr), 64'(wr));
        check_value("rsp_rdata", 64'(bus.rsp_rdata), 64'(wr ? last_rdata : exp_rd));
        check_value("resp_ready", 64'(bus.req_ready), 64'd0);
        check_value("resp_m_wr", 64'(bus.m_wr), 64'd0);
        if (wr) begin
            for (int b = 0; b < BYTES; b++) begin
                a = addr + ADDR'(b);
                ref_mem[a] = wd[b*DATA +: DATA];
            end
        end else begin
            last_rdata = exp_rd;
        end
        @(posedge clk);
        #1;
        check_value("rsp_once", 64'(bus.rsp_valid), 64'd0);
        check_value("idle_ready", 64'(bus.req_ready), 64'd1);
        check_value("hold_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
    endtask

    // Start a request and assert reset partway through cycle at_cycle
    // (counted from the accepting edge).
    task automatic abort_req(input bit wr, input logic [ADDR-1:0] addr,
                             input logic [WORD-1:0] wd, input int at_cycle);
        int              wait_c;
        int              written;
        logic [ADDR-1:0] a;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        wait_c = 0;
        while (!bus.req_ready && wait_c < 20) begin
            @(posedge clk);
            #1;
            wait_c++;
        end
        check_value("abort_accept", 64'(wait_c < 20), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int n = 1; n < at_cycle; n++) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        check_value("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_value("arst_m_wr", 64'(bus.m_wr), 64'd0);
        check_value("arst_m_addr", 64'(bus.m_addr), 64'd0);
        check_value("arst_m_din", 64'(bus.m_din), 64'd0);
        check_value("arst_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_value("arst_rsp_wr", 64'(bus.rsp_wr), 64'd0);
        written = wr ? ((at_cycle - 1 < BYTES) ? at_cycle - 1 : BYTES) : 0;
        for (int b = 0; b < written; b++) begin
            a = addr + ADDR'(b);
            ref_mem[a] = wd[b*DATA +: DATA];
        end
        last_rdata = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            check_value("post_rst_rsp", 64'(bus.rsp_valid), 64'd0);
            check_value("post_rst_ready", 64'(bus.req_ready), 64'd1);
        end
    endtask

    initial begin
        logic [DATA-1:0] old41;
        logic [ADDR-1:0] r_addr;
        bit              r_wr;
        bit              r_hold;

        n_checks   = 0;
        n_fail     = 0;
        last_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        #12;
        check_value("rst_ready", 64'(bus.req_ready), 64'd1);
        check_value("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_value("rst_rsp_wr", 64'(bus.rsp_wr), 64'd0);
        check_value("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_value("rst_m_wr", 64'(bus.m_wr), 64'd0);
        check_value("rst_m_addr", 64'(bus.m_addr), 64'd0);
        check_value("rst_m_din", 64'(bus.m_din), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Store then load, plain address
        do_req(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        do_req(1'b0, 16'h0010, 16'h0000, 1'b0);

        // Address wrap from 0xFFFF to 0x0000
        do_req(1'b1, 16'hFFFF, 16'h1234, 1'b0);
        check_value("wrap_lo", 64'(bram[16'hFFFF]), 64'h34);
        check_value("wrap_hi", 64'(bram[16'h0000]), 64'h12);
        do_req(1'b0, 16'hFFFF, 16'h0000, 1'b0);

        // Back-to-back with req_valid held high
        do_req(1'b1, 16'h0020, 16'hC3A7, 1'b1);
        do_req(1'b0, 16'h0020, 16'h0000, 1'b0);

        // Reset mid-load, then mid-store after the first byte is written
        abort_req(1'b0, 16'h0010, 16'h0000, 2);
        old41 = bram[16'h0041];
        abort_req(1'b1, 16'h0040, 16'hAA55, 2);
        check_value("abort_b0", 64'(bram[16'h0040]), 64'h55);
        check_value("abort_b1", 64'(bram[16'h0041]), 64'(old41));
        do_req(1'b0, 16'h0040, 16'h0000, 1'b0);

        // Randomised traffic over a small window and the wrap region
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom);
            r_hold = (i != 39) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r_addr = 16'hFFFE + ADDR'($urandom_range(0, 1));
            end else begin
                r_addr = 16'h0100 + ADDR'($urandom_range(0, 7));
            end
            do_req(r_wr, r_addr, WORD'($urandom), r_hold);
        end
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
